// File: rtl/vt_pkg.sv
// Shared types for the vertex transform block: Q(WI).(WF) word, 4x4 matrix, FSM states.
package vt_pkg;
    localparam int WI = 8;
    localparam int WF = 8;
    localparam int W  = WI + WF;

    typedef logic signed [W-1:0] fxp_t;
    typedef fxp_t mat4_t [16];
    typedef enum logic [2:0] {IDLE, ROW0, ROW1, ROW2, ROW3, DONE} vt_state_e;
endpackage

// File: rtl/vt_row_mac.sv
// One matrix row dotted with (vx,vy,vz,1): full-precision sum, single round, range check.
// Out-of-range handling selected by VT_SATURATE_EN (clamp) or its absence (wrap).
module vt_row_mac
    import vt_pkg::*;
(
    input  fxp_t i_m0,
    input  fxp_t i_m1,
    input  fxp_t i_m2,
    input  fxp_t i_m3,
    input  fxp_t i_vx,
    input  fxp_t i_vy,
    input  fxp_t i_vz,
    output fxp_t o_res,
    output logic o_ovf
);
    localparam int AW   = 2*W + 2;
    localparam int MAXV = (1 << (W-1)) - 1;
    localparam int MINV = -(1 << (W-1));

    logic signed [2*W-1:0] w_p0, w_p1, w_p2;
    logic signed [AW-1:0]  w_acc, w_rnd;
    logic                  w_hi, w_lo;

    assign w_p0 = (2*W)'(i_m0) * (2*W)'(i_vx);
    assign w_p1 = (2*W)'(i_m1) * (2*W)'(i_vy);
    assign w_p2 = (2*W)'(i_m2) * (2*W)'(i_vz);

    // Translate term is aligned to the Q(2WI).(2WF) product scale before summing.
    assign w_acc = AW'(w_p0) + AW'(w_p1) + AW'(w_p2) + (AW'(i_m3) <<< WF);
    assign w_rnd = (w_acc + AW'(1 << (WF-1))) >>> WF;

    assign w_hi  = w_rnd > AW'(MAXV);
    assign w_lo  = w_rnd < AW'(MINV);
    assign o_ovf = w_hi | w_lo;

`ifdef VT_SATURATE_EN
    assign o_res = w_hi ? fxp_t'(MAXV) : (w_lo ? fxp_t'(MINV) : w_rnd[W-1:0]);
`else
    assign o_res = w_rnd[W-1:0];
`endif
endmodule

// File: rtl/vertex_transform.sv
// Streams object-space vertices through a captured 4x4 Q8.8 matrix, one row per cycle.
// Build option VT_SATURATE_EN clamps out-of-range rows instead of wrapping.
module vertex_transform
    import vt_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [16*W-1:0] i_model_matrix,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [W-1:0]   i_vx,
    input  logic [W-1:0]   i_vy,
    input  logic [W-1:0]   i_vz,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [W-1:0]   o_ox,
    output logic [W-1:0]   o_oy,
    output logic [W-1:0]   o_oz,
    output logic [W-1:0]   o_ow,
    output logic           o_overflow,
    input  logic           i_ovf_clr
);
    vt_state_e r_state;
    mat4_t     r_mat;
    fxp_t      r_vx, r_vy, r_vz;
    fxp_t      r_o [4];
    logic      r_out_valid;
    logic      r_overflow;

    logic       w_accept;
    logic       w_rowact;
    logic [1:0] w_row;
    fxp_t       w_res;
    logic       w_ovf;

    assign o_in_ready = (r_state == IDLE) || ((r_state == DONE) && i_out_ready);
    assign w_accept   = i_in_valid & o_in_ready;

    always_comb begin
        w_row    = 2'd0;
        w_rowact = 1'b1;
        case (r_state)
            ROW0:    w_row = 2'd0;
            ROW1:    w_row = 2'd1;
            ROW2:    w_row = 2'd2;
            ROW3:    w_row = 2'd3;
            default: w_rowact = 1'b0;
        endcase
    end

    vt_row_mac u_mac (
        .i_m0  (r_mat[{w_row, 2'd0}]),
        .i_m1  (r_mat[{w_row, 2'd1}]),
        .i_m2  (r_mat[{w_row, 2'd2}]),
        .i_m3  (r_mat[{w_row, 2'd3}]),
        .i_vx  (r_vx),
        .i_vy  (r_vy),
        .i_vz  (r_vz),
        .o_res (w_res),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_vx        <= '0;
            r_vy        <= '0;
            r_vz        <= '0;
            for (int i = 0; i < 16; i++) r_mat[i] <= '0;
            for (int i = 0; i < 4; i++)  r_o[i]   <= '0;
        end else begin
            // Vertex and matrix are latched together so later matrix updates miss the vertex in flight.
            if (w_accept) begin
                r_vx <= i_vx;
                r_vy <= i_vy;
                r_vz <= i_vz;
                for (int i = 0; i < 16; i++) r_mat[i] <= i_model_matrix[i*W +: W];
            end
            if (w_rowact) r_o[w_row] <= w_res;
            if (w_rowact && w_ovf) r_overflow <= 1'b1;
            else if (i_ovf_clr)    r_overflow <= 1'b0;

            case (r_state)
                IDLE: if (w_accept) r_state <= ROW0;
                ROW0: r_state <= ROW1;
                ROW1: r_state <= ROW2;
                ROW2: r_state <= ROW3;
                ROW3: begin
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                end
                DONE: if (i_out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= i_in_valid ? ROW0 : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_overflow  = r_overflow;
    assign o_ox        = r_o[0];
    assign o_oy        = r_o[1];
    assign o_oz        = r_o[2];
    assign o_ow        = r_o[3];
endmodule
